// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the PIO edge poller.
// - poll_state_e : poller FSM encoding
// - PIO_ADDR_*   : register map of the Avalon PIO input responder
// - tmr_width()  : width of a down-counter able to hold the larger of two loads
package soc_system_pio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_EDGE   = 3'd1,
    ST_WAIT_EDGE = 3'd2,
    ST_CLR       = 3'd3,
    ST_RD_DATA   = 3'd4,
    ST_WAIT_DATA = 3'd5
  } poll_state_e;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Write-1-to-clear pattern for edge-capture bit 0.
  localparam logic [31:0] PIO_EDGE_CLR = 32'h0000_0001;

  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/soc_system_poll_timer.sv
// Loadable down-counter used both as the poll-interval timer (in IDLE) and
// as the read-latency counter (in the WAIT states).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (count -> RST_VAL)
//   load         : load load_val (wins over dec_en)
//   load_val     : value to load
//   dec_en       : decrement by one; saturates at zero
//   zero         : count == 0
//   last         : count <= 1, i.e. this is the final cycle of the interval
module soc_system_poll_timer #(
  parameter int           W       = 10,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load)                          count_d = load_val;
    else if (dec_en && count_q != '0)  count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= RST_VAL;
    else          count_q <= count_d;
  end

  assign zero = (count_q == '0);
  assign last = (count_q <= W'(1));

endmodule

// File: rtl/soc_system_pio_edge_poller.sv
// Avalon-MM initiator that polls a 1-bit PIO input responder for captured
// edges. On a captured edge it clears the capture bit (write-1), then reads
// the live level, and reports the event to fabric logic.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   enable              : polling allowed (only honoured in IDLE)
//   address, chipselect,
//   write_n, writedata  : registered Avalon-MM initiator outputs
//   readdata            : responder read data, bit 0 used
//   waitrequest         : responder stall
//   event_pulse         : one cycle per edge consumed
//   event_count         : edges consumed, wraps
//   level               : last sampled data-register bit 0
//   busy                : FSM not in IDLE
module soc_system_pio_edge_poller
  import soc_system_pio_pkg::*;
#(
  parameter int         POLL_INTERVAL = 1000,
  parameter logic [1:0] EDGE_ADDR     = PIO_ADDR_EDGECAP,
  parameter logic [1:0] DATA_ADDR     = PIO_ADDR_DATA,
  parameter int         READ_LATENCY  = 1,
  parameter int         COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic [1:0]         address,
  output logic               chipselect,
  output logic               write_n,
  output logic [31:0]        writedata,
  input  logic [31:0]        readdata,
  input  logic               waitrequest,
  output logic               event_pulse,
  output logic [COUNT_W-1:0] event_count,
  output logic               level,
  output logic               busy
);

  localparam int          TW       = tmr_width(POLL_INTERVAL, READ_LATENCY);
  localparam logic [TW-1:0] TMR_POLL = TW'(POLL_INTERVAL);
  localparam logic [TW-1:0] TMR_LAT  = TW'(READ_LATENCY);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("READ_LATENCY must be in 1..4");
    end
  endgenerate

  poll_state_e          state_d, state_q;
  logic                 tmr_load, tmr_dec, tmr_zero, tmr_last;
  logic [TW-1:0]        tmr_load_val;

  logic [1:0]           address_d, address_q;
  logic                 chipselect_d, chipselect_q;
  logic                 write_n_d, write_n_q;
  logic [31:0]          writedata_d, writedata_q;
  logic                 event_pulse_d, event_pulse_q;
  logic [COUNT_W-1:0]   event_count_d, event_count_q;
  logic                 level_d, level_q;
  logic                 busy_d, busy_q;

  // Only bit 0 of the responder data is meaningful.
  logic unused_rdata;
  assign unused_rdata = ^{readdata[31:1], tmr_zero};

  // One counter serves both the idle interval and the read latency; the two
  // uses never overlap because latency is only counted in the WAIT states.
  soc_system_poll_timer #(
    .W       (TW),
    .RST_VAL (TMR_POLL)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec_en   (tmr_dec),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  // Next state, timer control and event bookkeeping.
  always_comb begin
    state_d       = state_q;
    tmr_load      = 1'b0;
    tmr_load_val  = TMR_POLL;
    tmr_dec       = 1'b0;
    event_pulse_d = 1'b0;
    event_count_d = event_count_q;
    level_d       = level_q;

    unique case (state_q)
      // Timer holds the remaining idle cycles; with an interval of 0 it is
      // already "last", so one IDLE cycle is the minimum.
      ST_IDLE: begin
        if (enable) begin
          if (tmr_last) state_d = ST_RD_EDGE;
          else          tmr_dec = 1'b1;
        end
      end
      ST_RD_EDGE: begin
        if (!waitrequest) begin
          state_d      = ST_WAIT_EDGE;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_LAT;
        end
      end
      ST_WAIT_EDGE: begin
        if (tmr_last) begin
          if (readdata[0]) begin
            state_d = ST_CLR;
          end else begin
            state_d  = ST_IDLE;
            tmr_load = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CLR: begin
        if (!waitrequest) begin
          state_d       = ST_RD_DATA;
          event_pulse_d = 1'b1;
          event_count_d = event_count_q + COUNT_W'(1);
        end
      end
      ST_RD_DATA: begin
        if (!waitrequest) begin
          state_d      = ST_WAIT_DATA;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_LAT;
        end
      end
      ST_WAIT_DATA: begin
        if (tmr_last) begin
          level_d  = readdata[0];
          state_d  = ST_IDLE;
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tmr_load = 1'b1;
      end
    endcase
  end

  // Bus outputs are a registered decode of the next state, so they line up
  // with state_q while staying free of input-to-output paths.
  always_comb begin
    chipselect_d = (state_d == ST_RD_EDGE) || (state_d == ST_CLR) ||
                   (state_d == ST_RD_DATA);
    write_n_d    = (state_d != ST_CLR);
    writedata_d  = (state_d == ST_CLR) ? PIO_EDGE_CLR : 32'h0;
    busy_d       = (state_d != ST_IDLE);
    // Address is held through the WAIT states because the responder muxes
    // readdata from address every cycle; IDLE keeps the last value.
    address_d    = address_q;
    if ((state_d == ST_RD_EDGE) || (state_d == ST_WAIT_EDGE) || (state_d == ST_CLR))
      address_d = EDGE_ADDR;
    else if ((state_d == ST_RD_DATA) || (state_d == ST_WAIT_DATA))
      address_d = DATA_ADDR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      address_q     <= 2'd0;
      chipselect_q  <= 1'b0;
      write_n_q     <= 1'b1;
      writedata_q   <= 32'h0;
      event_pulse_q <= 1'b0;
      event_count_q <= '0;
      level_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      chipselect_q  <= chipselect_d;
      write_n_q     <= write_n_d;
      writedata_q   <= writedata_d;
      event_pulse_q <= event_pulse_d;
      event_count_q <= event_count_d;
      level_q       <= level_d;
      busy_q        <= busy_d;
    end
  end

  assign address     = address_q;
  assign chipselect  = chipselect_q;
  assign write_n     = write_n_q;
  assign writedata   = writedata_q;
  assign event_pulse = event_pulse_q;
  assign event_count = event_count_q;
  assign level       = level_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_soc_system_pio_edge_poller.sv
// Bench: poller paired with a PIO input responder model (edge capture with
// clear priority, registered readdata, latency 1). Expected events are
// queued when the responder hands out a set edge-capture bit; expected
// levels when it returns the data register. A monitor pops and compares.
module tb_soc_system_pio_edge_poller;

  localparam int P  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata = 32'h0;
  logic          waitrequest = 1'b0;
  logic          event_pulse;
  logic [CW-1:0] event_count;
  logic          level, busy;

  always #5 clk = ~clk;

  soc_system_pio_edge_poller #(
    .POLL_INTERVAL (P),
    .EDGE_ADDR     (2'd3),
    .DATA_ADDR     (2'd0),
    .READ_LATENCY  (1),
    .COUNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .event_pulse (event_pulse),
    .event_count (event_count),
    .level       (level),
    .busy        (busy)
  );

  int            checks = 0, failures = 0;
  int unsigned   cyc = 0;
  int            n_wr = 0, n_pulse = 0, n_exp = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [CW-1:0] ev_q[$];
  logic          lvl_q[$];
  int unsigned   rd3_t[$];

  logic          in_port = 1'b0, in_prev = 1'b0, edgecap = 1'b0;
  logic          stall_prev = 1'b0, sv_cs = 1'b0, sv_wn = 1'b1;
  logic [1:0]    sv_addr = 2'd0;
  logic          prev_busy = 1'b0, prev_pulse = 1'b0;

  int            stall_rd = 0, stall_clr = 0;
  bit            rnd_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // PIO input responder + expectation source.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stall_prev) begin
      chk("stall_cs", {31'b0, chipselect}, {31'b0, sv_cs});
      chk("stall_addr", {30'b0, address}, {30'b0, sv_addr});
      chk("stall_wn", {31'b0, write_n}, {31'b0, sv_wn});
    end
    stall_prev <= chipselect && waitrequest;
    sv_cs      <= chipselect;
    sv_addr    <= address;
    sv_wn      <= write_n;

    if (chipselect && !waitrequest) begin
      if (!write_n) begin
        n_wr++;
        chk("wr_addr", {30'b0, address}, 32'd3);
        chk("wr_data", writedata, 32'h1);
      end else if (address == 2'd3) begin
        rd3_t.push_back(cyc);
        if (edgecap) begin
          exp_cnt = exp_cnt + 1'b1;
          ev_q.push_back(exp_cnt);
          n_exp++;
        end
      end else if (address == 2'd0) begin
        lvl_q.push_back(in_port);
      end else begin
        chk("rd_addr", {30'b0, address}, 32'd0);
      end
    end

    // Clear-write beats a simultaneous new edge.
    if (chipselect && !waitrequest && !write_n && address == 2'd3 && writedata[0])
      edgecap <= 1'b0;
    else if (in_port && !in_prev)
      edgecap <= 1'b1;
    in_prev  <= in_port;
    readdata <= (address == 2'd3) ? {31'b0, edgecap} :
                (address == 2'd0) ? {31'b0, in_port} : 32'h0;
  end

  // Monitor: pops expectations whenever the DUT reports something.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (!(chipselect && !write_n)) chk("wdata_zero", writedata, 32'h0);
      if (event_pulse) begin
        n_pulse++;
        chk("pulse_width", {31'b0, prev_pulse}, 32'h0);
        if (ev_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: event_count=%0d with no event expected", event_count);
        end else begin
          chk("event_count", {30'b0, event_count}, {30'b0, ev_q.pop_front()});
        end
      end
      if (prev_busy && !busy && lvl_q.size() > 0)
        chk("level", {31'b0, level}, {31'b0, lvl_q.pop_front()});
    end
    prev_busy  = busy;
    prev_pulse = event_pulse;
  end

  task automatic tick();
    @(negedge clk);
    waitrequest = 1'b0;
    if (chipselect) begin
      if (write_n && address == 2'd3 && stall_rd > 0) begin
        waitrequest = 1'b1;
        stall_rd--;
      end else if (!write_n && stall_clr > 0) begin
        waitrequest = 1'b1;
        stall_clr--;
      end else if (rnd_stall && $urandom_range(3, 0) == 0) begin
        waitrequest = 1'b1;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0, t, cs_seen;
    logic [CW-1:0] wrap_exp [5];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    ticks(3);
    chk("rst_cs", {31'b0, chipselect}, 32'd0);
    chk("rst_wn", {31'b0, write_n}, 32'd1);
    chk("rst_addr", {30'b0, address}, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_pulse", {31'b0, event_pulse}, 32'd0);
    chk("rst_count", {30'b0, event_count}, 32'd0);
    chk("rst_level", {31'b0, level}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Idle polling: edge-capture read every P+2 cycles, nothing else.
    ticks(2);
    rd3_t.delete();
    w0 = n_wr;
    ticks(40);
    chk("idle_polls", {31'b0, rd3_t.size() >= 5}, 32'd1);
    for (int i = 1; i < rd3_t.size(); i++)
      chk("poll_period", rd3_t[i] - rd3_t[i-1], P + 2);
    chk("idle_no_write", n_wr, w0);
    chk("idle_count", {30'b0, event_count}, 32'd0);

    // Single edge.
    w0 = n_wr; p0 = n_pulse;
    ticks(10);
    in_port = 1'b1;
    for (t = 0; t < 60 && n_pulse == p0; t++) tick();
    if (n_pulse == p0) timeout("single_edge");
    ticks(30);
    chk("single_writes", n_wr - w0, 32'd1);
    chk("single_pulses", n_pulse - p0, 32'd1);
    chk("single_count", {30'b0, event_count}, 32'd1);
    chk("single_level", {31'b0, level}, 32'd1);
    chk("single_edgecap", {31'b0, edgecap}, 32'd0);

    // Stalls during RD_EDGE and CLR.
    in_port = 1'b0;
    ticks(10);
    w0 = n_wr; p0 = n_pulse;
    stall_rd = 3; stall_clr = 3;
    in_port = 1'b1;
    ticks(60);
    chk("stall_writes", n_wr - w0, 32'd1);
    chk("stall_pulses", n_pulse - p0, 32'd1);
    chk("stall_rd_used", stall_rd, 32'd0);
    chk("stall_clr_used", stall_clr, 32'd0);
    chk("stall_count", {30'b0, event_count}, 32'd2);

    // enable dropped during CLR.
    in_port = 1'b0;
    ticks(10);
    p0 = n_pulse;
    in_port = 1'b1;
    for (t = 0; t < 60 && !(chipselect && !write_n); t++) tick();
    if (!(chipselect && !write_n)) timeout("en_clr");
    enable = 1'b0;
    for (t = 0; t < 20 && busy; t++) tick();
    if (busy) timeout("en_finish");
    cs_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (chipselect || busy) cs_seen++;
    end
    chk("en_off_no_cs", cs_seen, 32'd0);
    chk("en_pulses", n_pulse - p0, 32'd1);
    chk("en_count", {30'b0, event_count}, 32'd3);
    enable = 1'b1;

    // Reset during WAIT_DATA.
    in_port = 1'b0;
    ticks(10);
    in_port = 1'b1;
    for (t = 0; t < 60 && !(chipselect && write_n && address == 2'd0); t++) tick();
    if (!(chipselect && write_n && address == 2'd0)) timeout("rst_rd_data");
    tick();
    chk("in_wait_data", {31'b0, busy && !chipselect && address == 2'd0}, 32'd1);
    reset_n = 1'b0;
    ev_q.delete(); lvl_q.delete(); exp_cnt = '0;
    tick();
    chk("mid_rst_cs", {31'b0, chipselect}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_count", {30'b0, event_count}, 32'd0);
    chk("mid_rst_level", {31'b0, level}, 32'd0);
    chk("mid_rst_wn", {31'b0, write_n}, 32'd1);
    reset_n = 1'b1;

    // Counter wrap with COUNT_W=2.
    p0 = n_pulse;
    for (int k = 0; k < 5; k++) begin
      in_port = 1'b0;
      ticks(8);
      in_port = 1'b1;
      w0 = n_pulse;
      for (t = 0; t < 60 && n_pulse == w0; t++) tick();
      if (n_pulse == w0) timeout("wrap_edge");
      ticks(2);
      chk("wrap_count", {30'b0, event_count}, {30'b0, wrap_exp[k]});
    end
    chk("wrap_pulses", n_pulse - p0, 32'd5);

    // Randomized traffic: toggling input, enable and waitrequest.
    rnd_stall = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15, 0) == 0) in_port = ~in_port;
      if ($urandom_range(99, 0) == 0) enable = ~enable;
      tick();
    end
    rnd_stall = 1'b0;
    enable = 1'b1;
    for (t = 0; t < 40 && busy; t++) tick();
    if (busy) timeout("drain");
    ticks(20);
    chk("sb_events_left", ev_q.size(), 32'd0);
    chk("sb_levels_left", lvl_q.size(), 32'd0);
    chk("pulse_total", n_pulse, n_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
